// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel down-counter timer.
package multi_timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int unsigned DEF_W       = 4;
  localparam int unsigned DEF_NCH     = 2;
  localparam int unsigned DEF_PRESC_W = 8;

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle for multi_timer; presc_div exists only with MULTI_TIMER_PRESCALER_EN.
interface multi_timer_if
  import multi_timer_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned NCH     = DEF_NCH
`ifdef MULTI_TIMER_PRESCALER_EN
  ,
  parameter int unsigned PRESC_W = DEF_PRESC_W
`endif
) ();

  logic [NCH-1:0]   en;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   mode;
  logic [NCH*W-1:0] init;
  logic [NCH-1:0]   irq_clr;
`ifdef MULTI_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_div;
`endif
  logic [NCH*W-1:0] out;
  logic [NCH-1:0]   tc;
  logic [NCH-1:0]   irq;

`ifdef MULTI_TIMER_PRESCALER_EN
  modport master (output en, load, mode, init, irq_clr, presc_div, input out, tc, irq);
  modport slave  (input en, load, mode, init, irq_clr, presc_div, output out, tc, irq);
`else
  modport master (output en, load, mode, init, irq_clr, input out, tc, irq);
  modport slave  (input en, load, mode, init, irq_clr, output out, tc, irq);
`endif

endinterface

// File: rtl/timer_channel.sv
// One down-counter channel: load/decrement/reload with registered tc pulse and sticky irq.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         en,
  input  logic         load,
  input  logic         mode,
  input  logic [W-1:0] init,
  input  logic         irq_clr,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         irq
);

  localparam logic [W-1:0] One = W'(1);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         irq_q, irq_d;
  logic         step;

  assign step = en && tick;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = init;
      reload_d = init;
    end else if (step && count_q > One) begin
      count_d = count_q - One;
    end else if (step && count_q == One) begin
      // Periodic reloads straight from 1, so the count never shows 0 there.
      count_d = (mode == MODE_PERIODIC) ? reload_q : '0;
      tc_d    = 1'b1;
    end
    irq_d = tc_d | (irq_q & ~irq_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '1;
      reload_q <= '1;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      irq_q    <= irq_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign irq   = irq_q;

endmodule

// File: rtl/multi_timer.sv
// NCH independent programmable down-counters sharing one tick.
// Optional MULTI_TIMER_PRESCALER_EN adds a presc_div-driven tick prescaler.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned NCH     = DEF_NCH
`ifdef MULTI_TIMER_PRESCALER_EN
  ,
  parameter int unsigned PRESC_W = DEF_PRESC_W
`endif
) (
  input logic          clk,
  input logic          rst,
  multi_timer_if.slave bus
);

  logic tick;

`ifdef MULTI_TIMER_PRESCALER_EN
  localparam logic [PRESC_W-1:0] POne = PRESC_W'(1);

  logic [PRESC_W-1:0] p_q, p_d;

  // Compare for equality only, so a divider lowered below p waits for the natural wrap.
  always_comb begin
    tick = (p_q == bus.presc_div);
    p_d  = tick ? '0 : p_q + POne;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  logic [NCH-1:0][W-1:0] count;
  logic [NCH-1:0]        tc;
  logic [NCH-1:0]        irq;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(
      .W(W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .en     (bus.en[i]),
      .load   (bus.load[i]),
      .mode   (bus.mode[i]),
      .init   (bus.init[i*W +: W]),
      .irq_clr(bus.irq_clr[i]),
      .count  (count[i]),
      .tc     (tc[i]),
      .irq    (irq[i])
    );
  end

  assign bus.out = count;
  assign bus.tc  = tc;
  assign bus.irq = irq;

endmodule
